// File: rtl/mem_ctrl_arb_pkg.sv
// Shared definitions for the memory-controller arbiter: FSM encoding, default sizing, helpers.
// Provides fallback values for the MEM_ADDRESS_LEN / MEM_LINE_WIDTH project macros.
`ifndef MEM_ADDRESS_LEN
`define MEM_ADDRESS_LEN 32
`endif
`ifndef MEM_LINE_WIDTH
`define MEM_LINE_WIDTH 128
`endif

package mem_ctrl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEFAULT_LATENCY = 5;
  localparam int DEFAULT_DEPTH   = 1024;

  // Width of a port index; never zero so single-port builds still get a legal vector.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Request arbiter producing a one-hot grant while enabled.
// MEM_CTRL_ARB_RR_EN selects round-robin; otherwise fixed priority, lowest index wins.
module mem_rr_arbiter #(
  parameter int N_PORTS = 2
) (
`ifdef MEM_CTRL_ARB_RR_EN
  input  logic               clk,
  input  logic               reset,
`endif
  input  logic [N_PORTS-1:0] req,
  input  logic               enable,
  output logic [N_PORTS-1:0] grant
);

`ifdef MEM_CTRL_ARB_RR_EN
  import mem_ctrl_arb_pkg::*;

  localparam int PTR_W = ptr_width(N_PORTS);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic             found;

  // Search starts one past the last winner, wrapping around all ports.
  always_comb begin
    int idx;
    grant = '0;
    win   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_PORTS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && req[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
        grant[PTR_W'(idx)] = enable;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= PTR_W'(N_PORTS - 1);
    end else if (enable && found) begin
      ptr <= win;
    end
  end
`else
  // Isolate the lowest set request bit.
  assign grant = enable ? (req & (~req + N_PORTS'(1))) : '0;
`endif

endmodule

// File: rtl/mem_ctrl_arb.sv
// Multi-port line memory controller: arbitrate, wait LATENCY cycles, access array, pulse response.
// Arbitration policy follows MEM_CTRL_ARB_RR_EN inside mem_rr_arbiter.
module mem_ctrl_arb
  import mem_ctrl_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = `MEM_ADDRESS_LEN,
  parameter int LINE_W  = `MEM_LINE_WIDTH,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_PORTS-1:0]         req,
  input  logic [N_PORTS-1:0]         we,
  input  logic [N_PORTS*ADDR_W-1:0]  addr,
  input  logic [N_PORTS*LINE_W-1:0]  wdata,
  output logic [LINE_W-1:0]          rdata,
  output logic [N_PORTS-1:0]         rvalid,
  output logic [N_PORTS-1:0]         wack,
  output logic                       busy
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = ptr_width(N_PORTS);

  state_t               state;
  state_t               state_d;
  logic [7:0]           cnt;
  logic [7:0]           cnt_d;
  logic [N_PORTS-1:0]   grant;
  logic [N_PORTS-1:0]   grant_q;
  logic [PTR_W-1:0]     gidx;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LINE_W-1:0]    wdata_q;
  logic [IDX_W-1:0]     line_idx;
  logic                 arb_en;
  logic                 access;

  logic [LINE_W-1:0]    mem [DEPTH];

  assign arb_en = (state == IDLE);

  mem_rr_arbiter #(
    .N_PORTS (N_PORTS)
  ) u_arb (
`ifdef MEM_CTRL_ARB_RR_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .req    (req),
    .enable (arb_en),
    .grant  (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[PTR_W'(i)]) gidx = PTR_W'(i);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (|grant) begin
          state_d = ACCESS;
          cnt_d   = 8'(LATENCY - 1);
        end
      end
      ACCESS: begin
        cnt_d = cnt - 8'd1;
        if (cnt == 8'd1) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign access   = (state == ACCESS) && (cnt == 8'd1);
  // Dropping the in-line offset and truncating to IDX_W wraps upper address bits silently.
  assign line_idx = IDX_W'(addr_q >> OFF_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (arb_en && (|grant)) begin
        grant_q <= grant;
        we_q    <= we[gidx];
        addr_q  <= addr[gidx*ADDR_W +: ADDR_W];
        wdata_q <= wdata[gidx*LINE_W +: LINE_W];
      end
      if (access && !we_q) rdata <= mem[line_idx];
    end
  end

  // NOTE: the array has no reset; its contents must survive reset and it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (access && we_q) mem[line_idx] <= wdata_q;
  end

  assign busy   = (state == ACCESS) || (state == RESP);
  assign rvalid = ((state == RESP) && !we_q) ? grant_q : '0;
  assign wack   = ((state == RESP) &&  we_q) ? grant_q : '0;

endmodule
